// File: rtl/ped_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ped_pkg
//  Description : Shared definitions for the multi-channel edge detector:
//                per-channel edge-select encodings and a constant clog2
//                helper used to size the debounce counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package ped_pkg;

    // Per-channel edge select. Bit 0 enables rising edges, bit 1 falling.
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0, clog2(2) = 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ped_channel.sv
`default_nettype none
// ============================================================================
//  Module      : ped_channel
//  Description : One channel of the edge detector: synchroniser, debounce
//                filter, run-time edge qualification, registered tick,
//                sticky flag and saturating event counter.
//  Ports       : clk, rst (sync, active-low)
//                i_level    raw asynchronous input
//                i_mode     edge select (off / rise / fall / both)
//                i_clr      clears the sticky flag (a same-cycle set wins)
//                i_cnt_clr  clears the event counter (a same-cycle tick
//                           then counts once)
//                o_stable   debounced level
//                o_tick     one-cycle registered event pulse
//                o_tick_nxt value o_tick takes at the next edge
//                o_flag     sticky event flag
//                o_evt_cnt  saturating event count
//  Revision    : 1.0 - initial release
// ============================================================================
module ped_channel
    import ped_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_level,
    input  logic [1:0]       i_mode,
    input  logic             i_clr,
    input  logic             i_cnt_clr,
    output logic             o_stable,
    output logic             o_tick,
    output logic             o_tick_nxt,
    output logic             o_flag,
    output logic [CNT_W-1:0] o_evt_cnt
);

    localparam int                  c_DB_MAX    = (DB_CYCLES > 2) ? DB_CYCLES : 2;
    localparam int                  c_DCNT_W    = clog2(c_DB_MAX);
    localparam logic [c_DCNT_W-1:0] c_DB_LAST   = c_DCNT_W'((DB_CYCLES > 1) ? DB_CYCLES - 1 : 0);
    localparam bit                  c_NO_FILTER = (DB_CYCLES <= 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DCNT_W-1:0]    r_dcnt;
    logic                   r_stable;
    logic                   r_tick;
    logic                   r_flag;
    logic [CNT_W-1:0]       r_evt_cnt;

    logic                   w_sample;
    logic                   w_commit;
    logic                   w_edge_ok;
    logic [c_DCNT_W-1:0]    w_dcnt_nxt;
    logic                   w_stable_nxt;
    logic                   w_tick_nxt;
    logic                   w_flag_nxt;
    logic [CNT_W-1:0]       w_cnt_base;
    logic [CNT_W-1:0]       w_cnt_nxt;

    assign w_sample = r_sync[SYNC_STAGES-1];

    always_comb begin
        // Debounce: count consecutive samples that disagree with the
        // committed level; any agreeing sample restarts the count.
        w_dcnt_nxt = '0;
        w_commit   = 1'b0;
        if (w_sample != r_stable) begin
            if (c_NO_FILTER || (r_dcnt == c_DB_LAST)) begin
                w_commit = 1'b1;
            end else begin
                w_dcnt_nxt = r_dcnt + 1'b1;
            end
        end
        w_stable_nxt = w_commit ? w_sample : r_stable;

        // On a commit the new level is w_sample, so 1 means a rising edge.
        w_edge_ok = 1'b0;
        case (i_mode)
            MODE_RISE: w_edge_ok = w_sample;
            MODE_FALL: w_edge_ok = ~w_sample;
            MODE_BOTH: w_edge_ok = 1'b1;
            default:   w_edge_ok = 1'b0;
        endcase
        w_tick_nxt = w_commit & w_edge_ok;

        // Set has priority over clear.
        w_flag_nxt = r_tick | (r_flag & ~i_clr);

        // Clear first, then count, so clear + tick leaves exactly one.
        w_cnt_base = i_cnt_clr ? '0 : r_evt_cnt;
        w_cnt_nxt  = w_cnt_base;
        if (r_tick && (w_cnt_base != {CNT_W{1'b1}})) begin
            w_cnt_nxt = w_cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync    <= '0;
            r_dcnt    <= '0;
            r_stable  <= 1'b0;
            r_tick    <= 1'b0;
            r_flag    <= 1'b0;
            r_evt_cnt <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_level};
            r_dcnt    <= w_dcnt_nxt;
            r_stable  <= w_stable_nxt;
            r_tick    <= w_tick_nxt;
            r_flag    <= w_flag_nxt;
            r_evt_cnt <= w_cnt_nxt;
        end
    end

    assign o_stable   = r_stable;
    assign o_tick     = r_tick;
    assign o_tick_nxt = w_tick_nxt;
    assign o_flag     = r_flag;
    assign o_evt_cnt  = r_evt_cnt;

endmodule
`default_nettype wire

// File: rtl/ped_multi.sv
`default_nettype none
// ============================================================================
//  Module      : ped_multi
//  Description : CH independent edge-detector channels with a combined,
//                registered any_tick output.
//  Ports       : clk, rst (sync, active-low)
//                level[CH]       raw asynchronous inputs
//                mode[2*CH]      edge select, channel i at [2i+1:2i]
//                clr[CH]         per-channel sticky-flag clear
//                cnt_clr         clears all event counters
//                stable[CH]      debounced levels
//                tick[CH]        one-cycle event pulses
//                any_tick        OR of tick, same timing as tick
//                flag[CH]        sticky event flags
//                evt_cnt[CH*CNT_W] saturating counters, channel i at
//                                [(i+1)*CNT_W-1 : i*CNT_W]
//  Revision    : 1.0 - initial release
// ============================================================================
module ped_multi
    import ped_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       level,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       clr,
    input  logic                cnt_clr,
    output logic [CH-1:0]       stable,
    output logic [CH-1:0]       tick,
    output logic                any_tick,
    output logic [CH-1:0]       flag,
    output logic [CH*CNT_W-1:0] evt_cnt
);

    logic [CH-1:0] w_tick_nxt;
    logic          r_any_tick;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        ped_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_level    (level[i]),
            .i_mode     (mode[2*i +: 2]),
            .i_clr      (clr[i]),
            .i_cnt_clr  (cnt_clr),
            .o_stable   (stable[i]),
            .o_tick     (tick[i]),
            .o_tick_nxt (w_tick_nxt[i]),
            .o_flag     (flag[i]),
            .o_evt_cnt  (evt_cnt[i*CNT_W +: CNT_W])
        );
    end

    // Registered from the channels' next-tick values so any_tick is aligned
    // with tick instead of lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_any_tick <= 1'b0;
        end else begin
            r_any_tick <= |w_tick_nxt;
        end
    end

    assign any_tick = r_any_tick;

endmodule
`default_nettype wire
